// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round countdown controller: arm, run, pause, expire
module round_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_W   = 5,
  parameter int MIN_SEC  = 3,
  parameter int WARN_SEC = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] time_v,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [TIME_W-1:0] sec_left,
  output logic              running,
  output logic              warn,
  output logic              end_f,
  output logic              end_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] MIN_V     = TIME_W'(MIN_SEC);
  localparam logic [TIME_W-1:0] WARN_V    = TIME_W'(WARN_SEC);
  localparam logic [TIME_W-1:0] ONE_V     = TIME_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic              end_pulse_q, end_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      sec_q       <= '0;
      end_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      end_pulse_q <= end_pulse_d;
    end
  end

  // A released pause counts in the same cycle, so no partial second is lost.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    sec_d       = sec_q;
    end_pulse_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      sec_d   = '0;
    end else if (load && (state_q == S_IDLE || state_q == S_ARMED ||
                          state_q == S_EXPIRED)) begin
      state_d = S_ARMED;
      presc_d = '0;
      sec_d   = (time_v < MIN_V) ? MIN_V : time_v;
    end else if (start && state_q == S_ARMED) begin
      state_d = S_RUN;
      presc_d = '0;
    end else if (state_q == S_RUN || state_q == S_PAUSED) begin
      if (pause) begin
        state_d = S_PAUSED;
      end else begin
        state_d = S_RUN;
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (sec_q != '0) begin
            sec_d = sec_q - ONE_V;
          end
          if (sec_q <= ONE_V) begin
            state_d     = S_EXPIRED;
            end_pulse_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  assign sec_left  = sec_q;
  assign running   = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign warn      = running && (sec_q != '0) && (sec_q <= WARN_V);
  assign end_f     = (state_q == S_EXPIRED);
  assign end_pulse = end_pulse_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - self-checking bench for round_timer_ctrl
module tb_round_timer_ctrl;

  localparam int TD = 4;
  localparam int MINS = 3;
  localparam int WARNS = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [4:0] time_v = '0;
  logic [4:0] sec_left;
  logic       running, warn, end_f, end_pulse;
  logic [8:0] obs;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a round is a budget minus whole seconds of active (unpaused) cycles.
  typedef enum int {M_IDLE, M_ARMED, M_ACTIVE, M_EXPIRED} mode_t;
  mode_t m_mode;
  int    m_budget, m_elapsed;
  bit    m_pulse;

  round_timer_ctrl #(.TICK_DIV(TD), .TIME_W(5), .MIN_SEC(MINS), .WARN_SEC(WARNS)) dut (
    .clk(clk), .rst(rst), .load(load), .time_v(time_v), .start(start),
    .pause(pause), .abort(abort), .sec_left(sec_left), .running(running),
    .warn(warn), .end_f(end_f), .end_pulse(end_pulse)
  );

  assign obs = {sec_left, running, warn, end_f, end_pulse};

  always #5 clk = ~clk;

  function automatic int m_sec();
    if (m_mode == M_ARMED) return m_budget;
    if (m_mode == M_ACTIVE) return m_budget - m_elapsed / TD;
    return 0;
  endfunction

  function automatic logic [8:0] m_obs();
    int s;
    s = m_sec();
    return {5'(s), m_mode == M_ACTIVE, (m_mode == M_ACTIVE) && s != 0 && s <= WARNS,
            m_mode == M_EXPIRED, m_pulse};
  endfunction

  function automatic logic [8:0] expv(input int s, input bit run, input bit ef, input bit ep);
    return {5'(s), run, run && s != 0 && s <= WARNS, ef, ep};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_budget = 0;
    m_elapsed = 0;
    m_pulse = 0;
  endtask

  task automatic cyc(input bit l, input int tv, input bit s, input bit p, input bit a);
    load = l; time_v = 5'(tv); start = s; pause = p; abort = a;
    @(posedge clk);
    m_pulse = 0;
    if (a) begin
      m_mode = M_IDLE; m_budget = 0; m_elapsed = 0;
    end else if (l && m_mode != M_ACTIVE) begin
      m_mode = M_ARMED; m_budget = (tv < MINS) ? MINS : tv; m_elapsed = 0;
    end else if (s && m_mode == M_ARMED) begin
      m_mode = M_ACTIVE; m_elapsed = 0;
    end else if (m_mode == M_ACTIVE && !p) begin
      m_elapsed++;
      if (m_budget - m_elapsed / TD == 0) begin
        m_mode = M_EXPIRED; m_pulse = 1;
      end
    end
    #1;
    load = 0; start = 0; abort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, pause, 0);
  endtask

  task automatic test_reset();
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL reset_hold obs=%h exp=000", obs); end
    @(negedge clk);
    rst = 0;
    model_reset();
    cyc(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL reset_start_no_load obs=%h exp=000", obs); end
  endtask

  task automatic test_countdown();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 6, 0, 0, 0);
    n_vec++;
    if (obs !== expv(6, 0, 0, 0)) begin n_err++; $display("FAIL cd_load obs=%h exp=%h", obs, expv(6, 0, 0, 0)); end
    cyc(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== expv(6, 1, 0, 0)) begin n_err++; $display("FAIL cd_start obs=%h exp=%h", obs, expv(6, 1, 0, 0)); end
    for (int s = 5; s >= 0; s--) begin
      idle(3);
      n_vec++;
      if (obs !== expv(s + 1, 1, 0, 0)) begin n_err++; $display("FAIL cd_hold s=%0d obs=%h exp=%h", s + 1, obs, expv(s + 1, 1, 0, 0)); end
      idle(1);
      n_vec++;
      if (s != 0 && obs !== expv(s, 1, 0, 0)) begin n_err++; $display("FAIL cd_tick s=%0d obs=%h exp=%h", s, obs, expv(s, 1, 0, 0)); end
      if (s == 0 && obs !== expv(0, 0, 1, 1)) begin n_err++; $display("FAIL cd_expire obs=%h exp=%h", obs, expv(0, 0, 1, 1)); end
    end
    idle(2);
    n_vec++;
    if (obs !== expv(0, 0, 1, 0)) begin n_err++; $display("FAIL cd_end_held obs=%h exp=%h", obs, expv(0, 0, 1, 0)); end
  endtask

  task automatic test_load_floor();
    int tv[3] = '{1, 0, 31};
    int ex[3] = '{3, 3, 31};
    for (int i = 0; i < 3; i++) begin
      cyc(1, tv[i], 0, 0, 0);
      n_vec++;
      if (obs !== expv(ex[i], 0, 0, 0)) begin n_err++; $display("FAIL floor tv=%0d obs=%h exp=%h", tv[i], obs, expv(ex[i], 0, 0, 0)); end
    end
  endtask

  task automatic test_pause();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 4, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
    n_vec++;
    if (obs !== expv(4, 1, 0, 0)) begin n_err++; $display("FAIL pause_frozen obs=%h exp=%h", obs, expv(4, 1, 0, 0)); end
    cyc(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== expv(4, 1, 0, 0)) begin n_err++; $display("FAIL pause_resume1 obs=%h exp=%h", obs, expv(4, 1, 0, 0)); end
    cyc(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== expv(3, 1, 0, 0)) begin n_err++; $display("FAIL pause_resume2 obs=%h exp=%h", obs, expv(3, 1, 0, 0)); end
  endtask

  task automatic test_abort_on_expiry();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(3 * TD - 1);
    n_vec++;
    if (obs !== expv(1, 1, 0, 0)) begin n_err++; $display("FAIL abort_pre obs=%h exp=%h", obs, expv(1, 1, 0, 0)); end
    cyc(0, 0, 0, 0, 1);
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL abort_tick obs=%h exp=000", obs); end
    idle(1);
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL abort_after obs=%h exp=000", obs); end
  endtask

  task automatic test_load_in_run();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(TD);
    cyc(1, 9, 0, 0, 0);
    n_vec++;
    if (obs !== expv(7, 1, 0, 0)) begin n_err++; $display("FAIL run_load_ignored obs=%h exp=%h", obs, expv(7, 1, 0, 0)); end
    idle(TD - 1);
    n_vec++;
    if (obs !== expv(6, 1, 0, 0)) begin n_err++; $display("FAIL run_continue obs=%h exp=%h", obs, expv(6, 1, 0, 0)); end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 10, 0, 0, 0);
    cyc(1, 12, 1, 0, 0);
    n_vec++;
    if (obs !== expv(12, 0, 0, 0)) begin n_err++; $display("FAIL load_beats_start obs=%h exp=%h", obs, expv(12, 0, 0, 0)); end
    cyc(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== expv(12, 1, 0, 0)) begin n_err++; $display("FAIL start_after obs=%h exp=%h", obs, expv(12, 1, 0, 0)); end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(5);
    #3 rst = 1;
    #1;
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL async_reset obs=%h exp=000", obs); end
    model_reset();
    #2 rst = 0;
    cyc(0, 0, 1, 0, 0);
    n_vec++;
    if (obs !== 9'h0) begin n_err++; $display("FAIL post_reset_start obs=%h exp=000", obs); end
  endtask

  task automatic test_random();
    bit p = 0;
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 31), $urandom_range(0, 5) == 0,
          p, $urandom_range(0, 59) == 0);
      n_vec++;
      if (obs !== m_obs()) begin n_err++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, m_obs()); end
    end
    pause = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_countdown();
    test_load_floor();
    test_pause();
    test_abort_on_expiry();
    test_load_in_run();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
